// File: rtl/serial_accumulator_pkg.sv
// Shared definitions for the serial accumulator: FSM state encoding and the
// default operand-count width.
package serial_accumulator_pkg;

  // Width of the operand-count field; the sum is 8 + LEN_W bits wide.
  localparam int DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Sum width: wide enough for (2^len_w - 1) operands of value 255.
  function automatic int sum_width(input int len_w);
    return 8 + len_w;
  endfunction

endpackage

// File: rtl/serial_accumulator_if.sv
// Handshake bundle between a requester (master) and the serial accumulator (slave).
//   start/len        : begin a run of len operands (sampled only when the block is idle)
//   in_valid/in_data : operand stream, transfers when in_valid && in_ready
//   in_ready         : block accepts an operand this cycle
//   out_valid/out_sum: result, held until out_ready
//   busy             : run in progress or result pending
interface serial_accumulator_if #(
  parameter int LEN_W = serial_accumulator_pkg::DEF_LEN_W
);
  localparam int SUM_W = serial_accumulator_pkg::sum_width(LEN_W);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [SUM_W-1:0] out_sum;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, busy
  );

endinterface

// File: rtl/serial_accumulator_cla.sv
// Existing 8-bit carry-look-ahead adder.
//   a, b : 8-bit operands
//   cin  : carry in
//   sum  : 8-bit sum
//   cout : carry out
module Carry_Look_Ahead_Adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] w_p;
  logic [7:0] w_g;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Carries are written as the recurrence c[i+1] = g[i] | p[i]&c[i]; the loop
  // unrolls into the flattened look-ahead sum-of-products terms.
  always_comb begin
    logic w_c;
    w_c  = cin;
    sum  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      sum[i] = w_p[i] ^ w_c;
      w_c    = w_g[i] | (w_p[i] & w_c);
    end
    cout = w_c;
  end

endmodule

// File: rtl/serial_accumulator.sv
// Serial accumulator: sums a run of len unsigned 8-bit operands.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_accumulator_if (start/len, operand stream,
//           result handshake, busy)
// The low byte is added by an 8-bit CLA; its carry-out bumps the upper
// LEN_W bits, which cannot overflow for up to 2^LEN_W-1 operands.
module serial_accumulator
  import serial_accumulator_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_accumulator_if.slave  bus
);

  state_t           r_state;
  logic [7:0]       r_acc_lo;
  logic [LEN_W-1:0] r_acc_hi;
  logic [LEN_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [7:0]       w_add_sum;
  logic             w_add_cout;
  logic             w_xfer;
  logic             w_last;

  Carry_Look_Ahead_Adder_8bit u_cla (
    .a    (r_acc_lo),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  // r_in_ready is high exactly while in ACCUM, so it qualifies transfers.
  assign w_xfer = bus.in_valid & r_in_ready;
  assign w_last = (r_cnt == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc_lo    <= '0;
      r_acc_hi    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_acc_lo <= '0;
            r_acc_hi <= '0;
            r_busy   <= 1'b1;
            if (bus.len != '0) begin
              r_cnt      <= bus.len;
              r_in_ready <= 1'b1;
              r_state    <= ST_ACCUM;
            end else begin
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end

        ST_ACCUM: begin
          if (w_xfer) begin
            r_acc_lo <= w_add_sum;
            r_acc_hi <= r_acc_hi + LEN_W'(w_add_cout);
            r_cnt    <= r_cnt - LEN_W'(1);
            if (w_last) begin
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.out_sum   = {r_acc_hi, r_acc_lo};

endmodule

// File: tb/tb_serial_accumulator.sv
// Self-checking bench for serial_accumulator. Inputs change and outputs are
// sampled on the falling clock edge; expected sums are queued when a run is
// started and popped when the result appears.
module tb_serial_accumulator;
  import serial_accumulator_pkg::*;

  localparam int LEN_W = DEF_LEN_W;
  localparam int SUM_W = 8 + LEN_W;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_accumulator_if #(.LEN_W(LEN_W)) bus ();

  serial_accumulator #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned      n_checks = 0;
  int unsigned      n_pass   = 0;
  logic [SUM_W-1:0] exp_q[$];
  logic [SUM_W-1:0] exp_v;

  task automatic run_start(input int unsigned n);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = LEN_W'($urandom);
  endtask

  // Presents one operand at the current falling edge; returns one cycle later.
  task automatic feed(input logic [7:0] d);
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL feed_ready: in_ready=%b want 1 (data %0d)", bus.in_ready, d);
    else n_pass++;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.in_ready  !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);  else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.busy      !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy);           else n_pass++;
    n_checks++; if (bus.out_sum   !== '0)   $display("FAIL rst_out_sum: got %0d want 0", bus.out_sum);    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL rst_idle: busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid); else n_pass++;
  endtask

  task automatic test_no_carry();
    bus.out_ready = 1'b1;
    exp_q.push_back(SUM_W'(1 + 2 + 3));
    run_start(3);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL nc_busy: got %b want 1", bus.busy); else n_pass++;
    feed(8'd1); feed(8'd2); feed(8'd3);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL nc_latency: out_valid=%b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== exp_v) $display("FAIL nc_sum: got %0d want %0d", bus.out_sum, exp_v); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL nc_pulse: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy); else n_pass++;
  endtask

  task automatic test_carry();
    int unsigned total = 0;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 15; i++) total += 255;
    exp_q.push_back(SUM_W'(total));
    run_start(15);
    for (int unsigned i = 0; i < 15; i++) feed(8'd255);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL cy_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== exp_v) $display("FAIL cy_sum: got %0d want %0d", bus.out_sum, exp_v); else n_pass++;
    n_checks++; if (bus.out_sum[SUM_W-1:8] !== LEN_W'(total / 256))
      $display("FAIL cy_acc_hi: got %0d want %0d", bus.out_sum[SUM_W-1:8], total / 256); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    exp_q.push_back(SUM_W'(200 + 100));
    run_start(2);
    feed(8'd200);
    for (int unsigned i = 0; i < 3; i++) begin
      n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
        $display("FAIL bp_gap%0d: in_ready=%b out_valid=%b want 1 0", i, bus.in_ready, bus.out_valid); else n_pass++;
      @(negedge clk);
    end
    feed(8'd100);
    exp_v = exp_q.pop_front();
    // Offer extra operands while the result is held; none may be taken.
    for (int unsigned i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd55;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_v || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: out_valid=%b sum=%0d in_ready=%b want 1 %0d 0",
                 i, bus.out_valid, bus.out_sum, bus.in_ready, exp_v); else n_pass++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_v)
      $display("FAIL bp_release: out_valid=%b sum=%0d want 1 %0d", bus.out_valid, bus.out_sum, exp_v); else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL bp_idle: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy); else n_pass++;
  endtask

  task automatic test_zero_len();
    bus.out_ready = 1'b0;
    exp_q.push_back('0);
    run_start(0);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL z_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== exp_v) $display("FAIL z_sum: got %0d want %0d", bus.out_sum, exp_v); else n_pass++;
    for (int unsigned i = 0; i < 2; i++) begin
      n_checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
        $display("FAIL z_ready%0d: in_ready=%b busy=%b want 0 1", i, bus.in_ready, bus.busy); else n_pass++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL z_idle: out_valid=%b in_ready=%b want 0 0", bus.out_valid, bus.in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    run_start(4);
    feed(8'd10); feed(8'd20);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_sum !== '0)
      $display("FAIL rm_async: in_ready=%b out_valid=%b busy=%b sum=%0d want 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_sum); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL rm_after: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy); else n_pass++;
    exp_q.push_back(SUM_W'(7));
    run_start(1);
    feed(8'd7);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_v)
      $display("FAIL rm_rerun: out_valid=%b sum=%0d want 1 %0d", bus.out_valid, bus.out_sum, exp_v); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    bus.out_ready = 1'b1;
    exp_q.push_back(SUM_W'(5 + 6 + 7));
    run_start(3);
    feed(8'd5);
    bus.start = 1'b1;
    bus.len   = LEN_W'(5);
    feed(8'd6);
    bus.start = 1'b0;
    feed(8'd7);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_v)
      $display("FAIL is_result: out_valid=%b sum=%0d want 1 %0d", bus.out_valid, bus.out_sum, exp_v); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL is_idle: busy=%b in_ready=%b want 0 0", bus.busy, bus.in_ready); else n_pass++;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_no_carry();
    test_carry();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_ignored_start();
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d left want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
